// File: rtl/sd_pkg.sv
// Shared SD-bus definitions used by the card-side responders and the host controller.
// Contents:
//   CMD_FRAME_BITS / RESP_FRAME_BITS : CMD-line frame widths
//   sd_state_e                       : command-responder FSM states
//   crc7_step / crc7_calc40          : CRC7 (x^7 + x^3 + 1, init 0), MSB first
package sd_pkg;

  localparam int CMD_FRAME_BITS  = 48;
  localparam int RESP_FRAME_BITS = 48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_WAIT_USER,
    S_NCR,
    S_SEND
  } sd_state_e;

  // One serial step of CRC7; the feedback taps land on bits 3 and 0.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  // CRC7 over the 40 protected bits of a CMD-line frame (start..argument).
  function automatic logic [6:0] crc7_calc40(input logic [39:0] data);
    logic [6:0] crc;
    crc = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      crc = crc7_step(crc, data[i]);
    end
    return crc;
  endfunction

endpackage

// File: rtl/sd_edge_sync.sv
// Synchronizes an asynchronous clock-like input into the clk domain and
// produces one-clk pulses on its rising and falling edges.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   async_i : asynchronous input (e.g. sdclk)
//   rise_o  : one-clk pulse after a synchronized 0->1 transition
//   fall_o  : one-clk pulse after a synchronized 1->0 transition
module sd_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pulses are combinational from the last stage so the consumer can
  // register its reaction one clk after the edge is seen.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/sdcmd_resp.sv
// Card-side SD CMD-line responder. Receives 48-bit host commands sampled on
// sdclk rising edges, checks them, hands them to a user model and sends the
// user's 48-bit response NCR sdclk rises after the command end bit.
// Ports:
//   clk, rstn            : system clock (>=4x sdclk), async active-low reset
//   sdclk, sdcmdin       : host clock and CMD line (asynchronous inputs)
//   sdcmdout, sdcmdoe    : card drive value and output enable for CMD
//   cmd_valid, crc_err   : one-clk pulses for an accepted / rejected frame
//   cmd_idx, cmd_arg     : last accepted command, held until the next one
//   resp_valid/resp_none : user reply or "no reply", sampled in S_WAIT_USER
//   resp_idx, resp_arg   : response index and argument fields
//   resp_nocrc           : send 7'h7F instead of the computed CRC (R3)
//   busy                 : high whenever the FSM is not idle
module sdcmd_resp
  import sd_pkg::*;
#(
  parameter int NCR         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sdclk,
  input  logic        sdcmdin,
  output logic        sdcmdout,
  output logic        sdcmdoe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  input  logic        resp_valid,
  input  logic        resp_none,
  input  logic [5:0]  resp_idx,
  input  logic [31:0] resp_arg,
  input  logic        resp_nocrc,
  output logic        busy
);

  localparam logic [5:0] NCR_LOAD = 6'(NCR - 1);

  logic sck_rise;
  logic sck_fall;

  sd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk_i  (clk),
    .rst_ni (rstn),
    .async_i(sdclk),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // Same depth as the sdclk path so the data bit lines up with its sample
  // edge. Resets to 1 (idle line) so a reset release never fakes a start bit.
  logic [SYNC_STAGES-1:0] cmd_sync_q;
  logic                   cmd_bit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cmd_sync_q <= '1;
    else       cmd_sync_q <= {cmd_sync_q[SYNC_STAGES-2:0], sdcmdin};
  end

  assign cmd_bit = cmd_sync_q[SYNC_STAGES-1];

  sd_state_e   state_q;
  logic [5:0]  bitcnt_q;
  logic [5:0]  ncrcnt_q;
  logic [46:0] rx_q;      // frame bits 46..0; the start bit is implied
  logic [47:0] tx_q;
  logic        tail_q;    // end bit has been driven, release on next fall
  logic        sdcmdout_q;
  logic        sdcmdoe_q;
  logic        cmd_valid_q;
  logic        crc_err_q;
  logic [5:0]  cmd_idx_q;
  logic [31:0] cmd_arg_q;

  logic        rx_good;
  logic [6:0]  resp_crc_d;

  assign rx_good    = rx_q[46] && rx_q[0] &&
                      (crc7_calc40({1'b0, rx_q[46:8]}) == rx_q[7:1]);
  assign resp_crc_d = resp_nocrc ? 7'h7F : crc7_calc40({2'b00, resp_idx, resp_arg});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      ncrcnt_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      tail_q      <= 1'b0;
      sdcmdout_q  <= 1'b1;
      sdcmdoe_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      cmd_idx_q   <= '0;
      cmd_arg_q   <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sck_rise && !cmd_bit) begin
            bitcnt_q <= 6'd46;
            state_q  <= S_RECV;
          end
        end
        S_RECV: begin
          if (sck_rise) begin
            rx_q     <= {rx_q[45:0], cmd_bit};
            bitcnt_q <= bitcnt_q - 6'd1;
            if (bitcnt_q == 6'd0) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (rx_good) begin
            cmd_valid_q <= 1'b1;
            cmd_idx_q   <= rx_q[45:40];
            cmd_arg_q   <= rx_q[39:8];
            state_q     <= S_WAIT_USER;
          end else begin
            crc_err_q   <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_WAIT_USER: begin
          if (resp_none) begin
            state_q <= S_IDLE;
          end else if (resp_valid) begin
            tx_q     <= {2'b00, resp_idx, resp_arg, resp_crc_d, 1'b1};
            ncrcnt_q <= NCR_LOAD;
            state_q  <= S_NCR;
          end
        end
        S_NCR: begin
          // Leaving on the rise that brings the count to zero puts the start
          // bit on the following fall, so the host samples it on rise NCR.
          if (sck_rise) begin
            ncrcnt_q <= ncrcnt_q - 6'd1;
            if (ncrcnt_q == 6'd1) begin
              bitcnt_q <= 6'd47;
              tail_q   <= 1'b0;
              state_q  <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (sck_fall) begin
            if (tail_q) begin
              sdcmdoe_q  <= 1'b0;
              sdcmdout_q <= 1'b1;
              tail_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              sdcmdoe_q  <= 1'b1;
              sdcmdout_q <= tx_q[bitcnt_q];
              if (bitcnt_q == 6'd0) tail_q   <= 1'b1;
              else                  bitcnt_q <= bitcnt_q - 6'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sdcmdout  = sdcmdout_q;
  assign sdcmdoe   = sdcmdoe_q;
  assign cmd_valid = cmd_valid_q;
  assign crc_err   = crc_err_q;
  assign cmd_idx   = cmd_idx_q;
  assign cmd_arg   = cmd_arg_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/sdcmd_resp.md
Name: sdcmd_resp

Overview:
Card-side responder for the SD CMD line. It lets the host command controller run closed-loop in simulation and on FPGA loopback, with no SD card attached. It samples the host-driven sdclk and CMD line in the system clock domain, then deframes and CRC-checks each 48-bit command and presents it to a user model. It then transmits the 48-bit response that the user supplies (R1/R3/R6/R7 format) after NCR sdclk cycles.

Parameters:
NCR, 2, sdclk rising edges from the command end bit to the response start bit (legal 2..64)
SYNC_STAGES, 2, synchronizer depth for sdclk and sdcmdin (>=2)

Ports:
clk  in  1  system clock; must be >=4x the sdclk frequency
rstn  in  1  asynchronous active-low reset
sdclk  in  1  SD clock from host, asynchronous to clk
sdcmdin  in  1  CMD line as seen by the card
sdcmdout  out  1  CMD value driven by the card
sdcmdoe  out  1  card output enable
cmd_valid  out  1  one-clk pulse: a good command has been received
cmd_idx  out  6  received command index; held until the next good command
cmd_arg  out  32  received argument; held until the next good command
crc_err  out  1  one-clk pulse: a frame was rejected
resp_valid  in  1  user supplies a response (sampled in WAIT_USER only)
resp_none  in  1  user declares no response, e.g. CMD0 (sampled in WAIT_USER only)
resp_idx  in  6  response index field (0x3F for R3)
resp_arg  in  32  response argument/status field
resp_nocrc  in  1  1: send the CRC field as 7'h7F (R3)
busy  out  1  high in every state other than IDLE

Behaviour:
- Reset (async, rstn=0): state=IDLE; sdcmdoe=0, sdcmdout=1, cmd_valid=0, crc_err=0, busy=0, cmd_idx=0, cmd_arg=0, all counters 0. The same values apply when rstn falls mid-frame: the frame is aborted silently.
- Synchronize sdclk and sdcmdin through SYNC_STAGES flops each.
  - rise = sync sdclk 0->1 (sample point); fall = sync sdclk 1->0 (drive point).
- CRC7: polynomial x^7+x^3+1, initial value 0. Covers bits 47..8 of the frame (start, transmission, index, argument), MSB first.
- IDLE: on rise with sdcmdin=0, enter RECV with bit counter=46.
- RECV: on each rise, shift in sdcmdin and decrement the counter. After bit 0 is sampled, go to CHECK.
- CHECK (1 clk): the frame is good iff transmission bit=1, CRC matches and end bit=1.
  - Good: pulse cmd_valid, load cmd_idx/cmd_arg, go to WAIT_USER.
  - Bad: pulse crc_err, go to IDLE.
- WAIT_USER: waits indefinitely.
  - resp_none: go to IDLE.
  - resp_valid: latch the response fields and the CRC (computed over {0,0,idx,arg}, or 7'h7F when resp_nocrc), load NCR counter=NCR-1, go to NCR.
  - If both are high in the same clk, resp_none wins.
- NCR: decrement on each rise. When it reaches 0, go to SEND with bit counter=47.
- SEND: on each fall, drive sdcmdoe=1 and sdcmdout=frame[counter], then decrement. Frame = {0,0,idx,arg,crc7,1}.
  - On the first fall after the end bit: sdcmdoe=0, sdcmdout=1, go to IDLE.
  - Response start bit is therefore driven NCR full sdclk periods after the command end bit was sampled (counted at sample points).
- Start bits on sdcmdin during WAIT_USER, NCR or SEND are ignored; no new command is accepted until IDLE.
- rise/fall with sdclk held constant: no progress. A stopped sdclk freezes the FSM in its current state.
- cmd_valid and crc_err are never asserted in the same cycle.

Decomposition:
- Shared package (sd_pkg): CRC7 step function (shared with the host controller), frame-width constants CMD_FRAME_BITS=48 and RESP_FRAME_BITS=48, and the FSM state enum {IDLE,RECV,CHECK,WAIT_USER,NCR,SEND}.
- One sub-module, sd_edge_sync: synchronizer plus rise/fall pulse generator for sdclk. It is reused later by the card-side data-line responder.

Test Plan:
- CMD8 frame 0x48_000001AA_87 at sdclk=clk/8 -> cmd_valid one clk, cmd_idx=8, cmd_arg=0x000001AA, crc_err=0. Then resp_valid with idx=8, arg=0x000001AA -> line carries 0x08_000001AA_13, and its start bit is exactly NCR=2 rises after the command end bit.
- CMD8 frame with the CRC byte corrupted to 0x89 -> crc_err pulse, no cmd_valid, sdcmdoe stays 0, busy back to 0.
- CMD0 frame 0x40_00000000_95 followed by resp_none -> cmd_idx=0, no drive on CMD, FSM returns to IDLE; a following CMD8 is accepted.
- ACMD41-style R3: resp_idx=0x3F, arg=0x80FF8000, resp_nocrc=1 -> line carries 0x3F_80FF8000_FF.
- rstn pulsed low mid-SEND (bit 20) -> sdcmdoe=0 and sdcmdout=1 asynchronously, busy=0; the next command is decoded normally.
- NCR=5 with a host start bit injected during NCR -> the start bit is ignored, and the response still starts after 5 rises.
